// File: rtl/analog_trace_capture_pkg.sv
// Shared types for the analog trace capture block: FSM state encoding and pointer sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_READ
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/analog_trace_capture_if.sv
// Readout stream of the trace capture: data/valid from the capture block, ready from the consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer holds out_ready low to stall; the source keeps out_data/out_valid stable.
interface analog_trace_capture_if #(
    parameter int WIDTH = 16
) ();

    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/analog_trace_capture_ram.sv
// Simple dual-port sample buffer, DEPTH x WIDTH, one write and one read port on a single clock.
// Latency: read data valid one cycle after re; rdata holds while re is low.
// Backpressure: none; the caller gates re.
module trace_ram
    import trace_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/analog_trace_capture.sv
// Triggered ring-buffer capture of a sampled analog signal with in-order readout; optional decimation under ANALOG_TRACE_DECIM_EN.
// Latency: first readout beat one cycle after entering READ; one beat per cycle thereafter.
// Backpressure: out_ready low stalls readout with out_data/out_valid held; capture itself never stalls.
module analog_trace_capture
    import trace_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 256,
    parameter int DECIM    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_val,
    input  logic signed [WIDTH-1:0] thresh,
    input  logic                    arm,
    analog_trace_capture_if.master  rd,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FILL_LAST = CW'(PRE_TRIG - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 2);
    localparam logic [CW-1:0] BEAT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_N   = CW'(DEPTH);
    localparam bit            POST_NONE = (DEPTH - PRE_TRIG - 1) == 0;

    state_t                  state, state_n;
    logic [AW-1:0]           wptr, rptr;
    logic [CW-1:0]           cnt, rcnt, acnt;
    logic signed [WIDTH-1:0] prev, thresh_l;
    logic [WIDTH-1:0]        ram_q;
    logic                    vld_q;
    logic                    smp_en, cap_we, cnt_en, trig, rd_en, accept, last_beat;

`ifdef ANALOG_TRACE_DECIM_EN
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [DW-1:0] dcnt;

    // Restarting at arm makes the first cycle after arm a sample cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
        end else if ((state == ST_IDLE && arm) || dcnt == DW'(DECIM - 1)) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    assign smp_en = (dcnt == '0);
`else
    assign smp_en = 1'b1;
`endif

    assign cap_we    = smp_en && (state == ST_FILL || state == ST_ARMED || state == ST_POST);
    assign cnt_en    = cap_we && (state == ST_FILL || state == ST_POST);
    assign trig      = (state == ST_ARMED) && smp_en && (prev < thresh_l) && (in_val >= thresh_l);
    assign accept    = vld_q && rd.out_ready;
    assign last_beat = (state == ST_READ) && accept && (acnt == BEAT_LAST);
    assign rd_en     = (state == ST_READ) && (rcnt != DEPTH_N) && (!vld_q || rd.out_ready);

    assign rd.out_valid = vld_q;
    assign rd.out_data  = vld_q ? ram_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (arm) state_n = ST_FILL;
            ST_FILL:  if (smp_en && cnt == FILL_LAST) state_n = ST_ARMED;
            ST_ARMED: if (trig) state_n = POST_NONE ? ST_READ : ST_POST;
            ST_POST:  if (smp_en && cnt == POST_LAST) state_n = ST_READ;
            ST_READ:  if (last_beat) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rcnt     <= '0;
            acnt     <= '0;
            prev     <= '0;
            thresh_l <= '0;
            vld_q    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_beat;

            if (state == ST_IDLE && arm) begin
                thresh_l <= thresh;
                wptr     <= '0;
            end else if (cap_we) begin
                wptr <= wptr + 1'b1;
                prev <= in_val;
            end

            if (state_n != state) begin
                cnt <= '0;
            end else if (cnt_en) begin
                cnt <= cnt + 1'b1;
            end

            // After the last post-trigger write the write pointer sits at T-PRE_TRIG mod DEPTH,
            // which is exactly the oldest sample of the window.
            if (state != ST_READ && state_n == ST_READ) begin
                rptr <= wptr + 1'b1;
                rcnt <= '0;
                acnt <= '0;
            end else begin
                if (rd_en) begin
                    rptr <= rptr + 1'b1;
                    rcnt <= rcnt + 1'b1;
                end
                if (accept) begin
                    acnt <= acnt + 1'b1;
                end
            end

            if (rd_en) begin
                vld_q <= 1'b1;
            end else if (accept) begin
                vld_q <= 1'b0;
            end
        end
    end

    trace_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (cap_we),
        .waddr (wptr),
        .wdata (in_val),
        .re    (rd_en),
        .raddr (rptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_analog_trace_capture.sv
// Bench for analog_trace_capture: directed ramps plus random waveforms checked against a window model.
module tb_analog_trace_capture;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int POST  = DEPTH - PRE - 1;
`ifdef ANALOG_TRACE_DECIM_EN
    localparam int DEC = 3;
`else
    localparam int DEC = 1;
`endif
    localparam int MAXC   = 240;
    localparam int BUDGET = 1500;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [WIDTH-1:0] in_val;
    logic signed [WIDTH-1:0] thresh;
    logic                    arm;
    logic                    busy;
    logic                    done;

    analog_trace_capture_if #(.WIDTH(WIDTH)) rd_if ();

    analog_trace_capture #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE),
        .DECIM    (DEC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_val (in_val),
        .thresh (thresh),
        .arm    (arm),
        .rd     (rd_if),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stim [MAXC];
    int exp_q[$];
    int got_q[$];

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample k is whatever in_val holds on the k-th sample cycle after arm.
    function automatic int find_trig(input int th);
        for (int k = PRE; (k + POST) * DEC < MAXC; k++) begin
            if (stim[(k-1)*DEC] < th && stim[k*DEC] >= th) return k;
        end
        return -1;
    endfunction

    task automatic set_samples(input int q[$]);
        for (int c = 0; c < MAXC; c++) begin
            stim[c] = q[(c / DEC < q.size()) ? c / DEC : q.size() - 1];
        end
    endtask

    task automatic run_capture(input int th, input int rmode, input bit extra_arm, input bit do_rst);
        int  ti, ndone, rst_c;
        bit  stall, finished;
        logic signed [31:0] hold;
        ti = find_trig(th);
        exp_q.delete();
        got_q.delete();
        if (ti >= 0) begin
            for (int k = ti - PRE; k <= ti + POST; k++) exp_q.push_back(stim[k*DEC]);
        end
        rst_c    = ti * DEC + 3;
        stall    = 1'b0;
        finished = 1'b0;
        ndone    = 0;
        hold     = '0;
        thresh   = WIDTH'(th);
        arm      = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int c = 0; c < BUDGET && !finished; c++) begin
            in_val = (c < MAXC) ? WIDTH'(stim[c]) : '0;
            if (do_rst && c == rst_c) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_valid", rd_if.out_valid, 0);
                chk("rst_data", rd_if.out_data, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (done) ndone++;
                end
                chk("rst_no_done", ndone, 0);
                return;
            end
            if (stall) begin
                chk("stall_valid", rd_if.out_valid, 1);
                chk("stall_data", rd_if.out_data, hold);
            end
            if (done) begin
                ndone++;
                finished = 1'b1;
                chk("busy_at_done", busy, 0);
                chk("valid_at_done", rd_if.out_valid, 0);
            end
            case (rmode)
                0:       rd_if.out_ready = 1'b1;
                1:       rd_if.out_ready = 1'($urandom_range(1, 0));
                default: rd_if.out_ready = (c % 4 == 0) || (c % 4 == 3);
            endcase
            arm = extra_arm && ((c == PRE * DEC) || (rd_if.out_valid && got_q.size() == 0) ||
                  (rd_if.out_valid && rd_if.out_ready && got_q.size() == DEPTH - 1));
            if (rd_if.out_valid && rd_if.out_ready) got_q.push_back(int'(rd_if.out_data));
            stall = rd_if.out_valid && !rd_if.out_ready;
            hold  = rd_if.out_data;
            @(negedge clk);
        end
        arm = 1'b0;
        chk("done_seen", finished, 1);
        repeat (4) begin
            if (done) ndone++;
            chk("idle_busy", busy, 0);
            chk("idle_valid", rd_if.out_valid, 0);
            @(negedge clk);
        end
        chk("done_once", ndone, 1);
        chk("beat_count", got_q.size(), DEPTH);
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            chk("beat_data", got_q[k], exp_q[k]);
        end
    endtask

    task automatic load_ramp();
        for (int c = 0; c < MAXC; c++) stim[c] = -8 + c / DEC;
    endtask

    task automatic check_ramp(input string tag);
        for (int k = 0; k < got_q.size(); k++) chk(tag, got_q[k], -4 + k);
    endtask

    initial begin
        int q[$];
        int th, tries;
        rst    = 1'b1;
        arm    = 1'b0;
        in_val = '0;
        thresh = '0;
        rd_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", rd_if.out_valid, 0);
        chk("reset_data", rd_if.out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp through zero: trigger on sample 0, window -4..11.
        load_ramp();
        run_capture(0, 0, 1'b0, 1'b0);
        check_ramp("t1_ramp");

        // Crossing inside FILL is ignored; next upward crossing triggers.
        q = '{-5, 2, 3, -1, -2, -3, 5, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 20, 20};
        set_samples(q);
        run_capture(0, 0, 1'b0, 1'b0);
        if (got_q.size() == DEPTH) begin
            chk("t2_first", got_q[0], 3);
            chk("t2_trig", got_q[PRE], 5);
            chk("t2_last", got_q[DEPTH-1], 20);
        end else begin
            chk("t2_size", got_q.size(), DEPTH);
        end

        // Backpressure pattern 1,0,0,1.
        load_ramp();
        run_capture(0, 2, 1'b0, 1'b0);
        check_ramp("t3_stall");

        // Reset in the third POST cycle, then a clean capture.
        load_ramp();
        run_capture(0, 0, 1'b0, 1'b1);
        run_capture(0, 0, 1'b0, 1'b0);
        check_ramp("t4_rearm");

        // Stray arm pulses during ARMED, READ and on the final beat.
        load_ramp();
        run_capture(0, 0, 1'b1, 1'b0);
        check_ramp("t5_arm");

        // Random waveforms, random thresholds, random backpressure.
        for (int t = 0; t < 3; t++) begin
            tries = 0;
            do begin
                th = int'($urandom_range(100, 0)) - 50;
                for (int c = 0; c < MAXC; c++) stim[c] = int'($urandom_range(200, 0)) - 100;
                tries++;
            end while (find_trig(th) < 0 && tries < 100);
            run_capture(th, 1, 1'b0, 1'b0);
        end

`ifdef ANALOG_TRACE_DECIM_EN
        for (int c = 0; c < MAXC; c++) stim[c] = c;
        run_capture(40, 0, 1'b0, 1'b0);
        for (int k = 1; k < got_q.size(); k++) chk("t6_step", got_q[k] - got_q[k-1], 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/analog_trace_capture.md
ANALOG_TRACE_CAPTURE -- requirements
Module: analog_trace_capture

Interface
REQ-001 Parameter WIDTH, default 16: width of the signed fixed-point sample word, same encoding as the probed real signal.
REQ-002 Parameter DEPTH, default 1024: number of buffered samples; SHALL be a power of two and at least 4.
REQ-003 Parameter PRE_TRIG, default 256: number of samples kept before the trigger sample; SHALL be at least 1 and at most DEPTH-2.
REQ-004 Parameter DECIM, default 1: sample-enable divider; used only under ANALOG_TRACE_DECIM_EN.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_val  input  WIDTH  signed sample of the probed analog signal.
REQ-008 thresh  input  WIDTH  signed trigger threshold, sampled at arm.
REQ-009 arm  input  1  single-cycle pulse that starts a capture.
REQ-010 out_data  output  WIDTH  readout sample.
REQ-011 out_valid  output  1  out_data holds a valid readout sample.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last readout beat is accepted.

Function
REQ-015 FSM states: IDLE, FILL, ARMED, POST, READ.
- IDLE -> FILL on arm; thresh is latched, write pointer and counters are cleared.
REQ-016 FILL writes one sample per sample-enable; -> ARMED after PRE_TRIG writes.
REQ-017 ARMED writes continuously into the ring.
- Trigger = prev sample < thresh_latched and current sample >= thresh_latched, signed compare.
- prev is the last written sample.
- The trigger is evaluated only when a sample is taken.
REQ-018 The trigger sample is written at address T; -> POST in the same cycle.
REQ-019 POST writes DEPTH-PRE_TRIG-1 more samples, then -> READ.
- If DEPTH-PRE_TRIG-1 = 0, go directly to READ.
REQ-020 READ emits exactly DEPTH samples in chronological order, starting at address (T-PRE_TRIG) mod DEPTH and wrapping modulo DEPTH.
REQ-021 Readout uses a synchronous RAM read with 1-cycle latency.
- out_data and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
- Full throughput: one beat per cycle while out_ready=1.
REQ-022 After the DEPTH-th beat is accepted: done pulses, out_valid drops the next cycle, FSM -> IDLE.
REQ-023 arm in any state other than IDLE is ignored.
- arm in the same cycle as the final accepted beat is also ignored.
REQ-024 Pointer arithmetic is log2(DEPTH) bits and wraps naturally.
- Sample counters are log2(DEPTH)+1 bits.
REQ-025 A trigger condition during FILL is ignored; prev still updates.

Reset
REQ-026 On rst: FSM=IDLE; pointers, counters, prev and thresh_latched are cleared; out_valid=0, out_data=0, busy=0, done=0.
REQ-027 rst mid-capture or mid-readout aborts immediately.
- No done pulse.
- RAM contents are undefined afterwards.

Configuration
REQ-028 Macro ANALOG_TRACE_DECIM_EN defined: a counter generates a sample-enable every DECIM cycles, and FILL/ARMED/POST write only on enable.
- The counter is reset at arm.
- The first enable occurs on the first cycle after arm.
- READ is unaffected by the counter.
REQ-029 Macro not defined: the sample-enable is constant 1, and the DECIM counter logic and parameter use are absent from the netlist.

Structure
REQ-030 Package trace_pkg holds the FSM state enum and a function clog2-based pointer-width constant helper.
REQ-031 Sub-module trace_ram: simple dual-port RAM, DEPTH x WIDTH, with a synchronous write port and a synchronous 1-cycle read port, inferable as block RAM.

Verification (WIDTH=16, DEPTH=16, PRE_TRIG=4, DECIM=1 unless noted)
REQ-032 Test 1: ramp in_val = -8, -7, ...; thresh=0; arm at cycle 0; out_ready=1.
- The trigger sample is 0.
- Readout = -4..11 (16 beats).
- done pulses once.
- busy falls after done.
REQ-033 Test 2: in_val rises through 0 at the 2nd sample after arm (inside FILL).
- That crossing is ignored.
- Capture triggers on the next upward crossing.
- Readout shows 4 samples before that crossing.
REQ-034 Test 3: out_ready toggles in the pattern 1,0,0,1 during READ.
- out_data stays stable while stalled.
- All 16 beats arrive in order with no duplicates and no gaps.
REQ-035 Test 4: rst asserted in the 3rd POST cycle, then arm again.
- Outputs reach their reset values asynchronously.
- No done pulse.
- The second capture completes correctly.
REQ-036 Test 5: arm pulsed during ARMED and READ.
- No effect on state or readout.
REQ-037 Test 6: with ANALOG_TRACE_DECIM_EN, DECIM=3, ramp +1 per clk.
- Consecutive readout samples differ by 3.
